// File: rtl/sad_pkg.sv
// sad_pkg
//   Shared definitions for the SAD minimum tracker: default widths, a
//   constant-evaluable clog2, a helper giving the node count of each tree
//   level, and the compare rule used by both the tree and the running stage.
package sad_pkg;

    localparam int SAD_W_DEF = 16;
    localparam int VEC_W_DEF = 8;

    // Compare operands are zero-extended to this width, so any SAD_W up to
    // 64 bits compares as a full-width unsigned value.
    localparam int CMP_W = 64;
    typedef logic [CMP_W-1:0] cmp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Number of nodes present at tree level lvl (level 0 = the raw candidates).
    function automatic int nodes_at(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
        return c;
    endfunction

    // Left operand must always be the lower-index side.
    function automatic logic cmp_wins(input cmp_t l, input cmp_t r, input logic tie_low);
        return (l < r) || ((l == r) && tie_low);
    endfunction

endpackage

// File: rtl/sad_cmp_node.sv
// sad_cmp_node
//   One registered compare-select node of the reduction tree. Loads the
//   winner of (left, right) when en is high, otherwise holds.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   en             upstream level holds a valid beat
//   l_sad, l_idx   lower-index operand
//   r_sad, r_idx   higher-index operand
//   sad, idx       registered winner
module sad_cmp_node
    import sad_pkg::*;
#(
    parameter int SAD_W   = SAD_W_DEF,
    parameter int IDX_W   = 4,
    parameter int TIE_LOW = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SAD_W-1:0] l_sad,
    input  logic [IDX_W-1:0] l_idx,
    input  logic [SAD_W-1:0] r_sad,
    input  logic [IDX_W-1:0] r_idx,
    output logic [SAD_W-1:0] sad,
    output logic [IDX_W-1:0] idx
);

    localparam logic TIE_BIT = (TIE_LOW != 0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sad <= '0;
            idx <= '0;
        end else if (en) begin
            if (cmp_wins(cmp_t'(l_sad), cmp_t'(r_sad), TIE_BIT)) begin
                sad <= l_sad;
                idx <= l_idx;
            end else begin
                sad <= r_sad;
                idx <= r_idx;
            end
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// sad_min_tracker
//   Reduces NUM_CAND SADs per beat with a registered compare-select tree and
//   tracks the running minimum across a first..last search. The winning SAD,
//   its absolute vector index and the beat count are held on a valid/ready
//   result port.
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid              beat valid (no backpressure)
//   in_first, in_last     search delimiters, qualified by in_valid
//   cand_base             index of candidate 0 in this beat
//   sad_vec               candidate k at [k*SAD_W +: SAD_W]
//   out_valid, out_ready  result handshake
//   best_sad, best_idx    winning SAD and index of the completed search
//   beat_cnt              beats in the completed search, saturating
//   overflow              sticky, a pending result was overwritten
module sad_min_tracker
    import sad_pkg::*;
#(
    parameter int NUM_CAND = 9,
    parameter int SAD_W    = SAD_W_DEF,
    parameter int VEC_W    = VEC_W_DEF,
    parameter int TIE_LOW  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [VEC_W-1:0]          cand_base,
    input  logic [NUM_CAND*SAD_W-1:0] sad_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAD_W-1:0]          best_sad,
    output logic [VEC_W-1:0]          best_idx,
    output logic [15:0]               beat_cnt,
    output logic                      overflow
);

    localparam int   LVL     = clog2(NUM_CAND);
    localparam int   IDX_W   = LVL;
    localparam logic TIE_BIT = (TIE_LOW != 0);

    // Level 0: input latch.
    logic [SAD_W-1:0] l0_sad [NUM_CAND];
    logic             l0_valid, l0_first, l0_last;
    logic [VEC_W-1:0] l0_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l0_valid <= 1'b0;
            l0_first <= 1'b0;
            l0_last  <= 1'b0;
            l0_base  <= '0;
            for (int k = 0; k < NUM_CAND; k++) l0_sad[k] <= '0;
        end else begin
            l0_valid <= in_valid;
            if (in_valid) begin
                l0_first <= in_first;
                l0_last  <= in_last;
                l0_base  <= cand_base;
                for (int k = 0; k < NUM_CAND; k++) l0_sad[k] <= sad_vec[k*SAD_W +: SAD_W];
            end
        end
    end

    // Levels 1..LVL: pairwise reduction. Beat control rides alongside each level.
    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        localparam int N_IN  = nodes_at(NUM_CAND, l - 1);
        localparam int N_OUT = (N_IN + 1) / 2;

        logic [SAD_W-1:0] in_sad [N_IN];
        logic [IDX_W-1:0] in_idx [N_IN];
        logic             in_v, in_f, in_l;
        logic [VEC_W-1:0] in_b;

        logic [SAD_W-1:0] lv_sad [N_OUT];
        logic [IDX_W-1:0] lv_idx [N_OUT];
        logic             lv_valid, lv_first, lv_last;
        logic [VEC_W-1:0] lv_base;

        if (l == 1) begin : g_src
            for (genvar k = 0; k < N_IN; k++) begin : g_k
                assign in_sad[k] = l0_sad[k];
                assign in_idx[k] = IDX_W'(k);
            end
            assign in_v = l0_valid;
            assign in_f = l0_first;
            assign in_l = l0_last;
            assign in_b = l0_base;
        end else begin : g_src
            for (genvar k = 0; k < N_IN; k++) begin : g_k
                assign in_sad[k] = g_lvl[l-1].lv_sad[k];
                assign in_idx[k] = g_lvl[l-1].lv_idx[k];
            end
            assign in_v = g_lvl[l-1].lv_valid;
            assign in_f = g_lvl[l-1].lv_first;
            assign in_l = g_lvl[l-1].lv_last;
            assign in_b = g_lvl[l-1].lv_base;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lv_valid <= 1'b0;
                lv_first <= 1'b0;
                lv_last  <= 1'b0;
                lv_base  <= '0;
            end else begin
                lv_valid <= in_v;
                if (in_v) begin
                    lv_first <= in_f;
                    lv_last  <= in_l;
                    lv_base  <= in_b;
                end
            end
        end

        for (genvar p = 0; p < N_OUT; p++) begin : g_p
            logic [SAD_W-1:0] n_sad;
            logic [IDX_W-1:0] n_idx;

            if (2*p + 1 < N_IN) begin : g_node
                sad_cmp_node #(
                    .SAD_W   (SAD_W),
                    .IDX_W   (IDX_W),
                    .TIE_LOW (TIE_LOW)
                ) u_node (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (in_v),
                    .l_sad (in_sad[2*p]),
                    .l_idx (in_idx[2*p]),
                    .r_sad (in_sad[2*p+1]),
                    .r_idx (in_idx[2*p+1]),
                    .sad   (n_sad),
                    .idx   (n_idx)
                );
            end else begin : g_pass
                // Odd node: registered pass-through, never compared against padding.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        n_sad <= '0;
                        n_idx <= '0;
                    end else if (in_v) begin
                        n_sad <= in_sad[2*p];
                        n_idx <= in_idx[2*p];
                    end
                end
            end

            assign lv_sad[p] = n_sad;
            assign lv_idx[p] = n_idx;
        end
    end

    // Tree output.
    logic             t_valid, t_first, t_last;
    logic [SAD_W-1:0] t_sad;
    logic [VEC_W-1:0] t_abs;

    assign t_valid = g_lvl[LVL].lv_valid;
    assign t_first = g_lvl[LVL].lv_first;
    assign t_last  = g_lvl[LVL].lv_last;
    assign t_sad   = g_lvl[LVL].lv_sad[0];
    assign t_abs   = g_lvl[LVL].lv_base + VEC_W'(g_lvl[LVL].lv_idx[0]);

    // Running-min stage.
    logic             run_open;
    logic [SAD_W-1:0] run_sad;
    logic [VEC_W-1:0] run_idx;
    logic [15:0]      run_cnt;

    logic             take, complete, new_wins;
    logic [SAD_W-1:0] cand_sad;
    logic [VEC_W-1:0] cand_idx;
    logic [15:0]      cand_cnt;

    always_comb begin
        take     = t_valid && (t_first || run_open);
        complete = take && t_last;
        // The stored result is always treated as the lower-index side.
        new_wins = !cmp_wins(cmp_t'(run_sad), cmp_t'(t_sad), TIE_BIT);
        cand_sad = t_sad;
        cand_idx = t_abs;
        cand_cnt = 16'd1;
        if (!t_first) begin
            if (!new_wins) begin
                cand_sad = run_sad;
                cand_idx = run_idx;
            end
            cand_cnt = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_open <= 1'b0;
            run_sad  <= '0;
            run_idx  <= '0;
            run_cnt  <= '0;
        end else if (take) begin
            run_open <= !t_last;
            run_sad  <= cand_sad;
            run_idx  <= cand_idx;
            run_cnt  <= cand_cnt;
        end
    end

    // Result holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            best_sad  <= '0;
            best_idx  <= '0;
            beat_cnt  <= '0;
            overflow  <= 1'b0;
        end else if (complete) begin
            out_valid <= 1'b1;
            best_sad  <= cand_sad;
            best_idx  <= cand_idx;
            beat_cnt  <= cand_cnt;
            if (out_valid && !out_ready) overflow <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sad_min_tracker.sv
// tb_sad_min_tracker
//   Directed bench: expected results are queued when a search is driven and
//   compared when the primary DUT (TIE_LOW=1) hands a result over. A second
//   instance with TIE_LOW=0 sees the same stimulus for the tie cases.
module tb_sad_min_tracker;

    localparam int NC = 9;

    typedef struct packed {
        logic [15:0] sad;
        logic [7:0]  idx;
        logic [15:0] cnt;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_first, in_last;
    logic [7:0]        cand_base;
    logic [NC*16-1:0]  sad_vec;
    logic              out_ready;

    logic              out_valid, overflow;
    logic [15:0]       best_sad, beat_cnt;
    logic [7:0]        best_idx;

    logic              out_valid1, overflow1;
    logic [15:0]       best_sad1, beat_cnt1;
    logic [7:0]        best_idx1;

    logic [15:0]       cand [NC];
    exp_t              sb [$];
    int                n_checks = 0;
    int                n_pass   = 0;

    always #5 clk = ~clk;

    sad_min_tracker #(.NUM_CAND(NC), .SAD_W(16), .VEC_W(8), .TIE_LOW(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .cand_base(cand_base), .sad_vec(sad_vec), .out_valid(out_valid), .out_ready(out_ready),
        .best_sad(best_sad), .best_idx(best_idx), .beat_cnt(beat_cnt), .overflow(overflow)
    );

    sad_min_tracker #(.NUM_CAND(NC), .SAD_W(16), .VEC_W(8), .TIE_LOW(0)) dut_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .cand_base(cand_base), .sad_vec(sad_vec), .out_valid(out_valid1), .out_ready(1'b1),
        .best_sad(best_sad1), .best_idx(best_idx1), .beat_cnt(beat_cnt1), .overflow(overflow1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int k = 0; k < NC; k++) cand[k] = v;
    endtask

    task automatic beat(input logic f, input logic l, input logic [7:0] b);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_first  = f;
        in_last   = l;
        cand_base = b;
        for (int k = 0; k < NC; k++) sad_vec[k*16 +: 16] = cand[k];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    // Scoreboard: one pop per handshake on the primary DUT.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sad", 32'(best_sad), 32'(e.sad));
                check("sb_idx", 32'(best_idx), 32'(e.idx));
                check("sb_cnt", 32'(beat_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit early, seen, stable;

        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        cand_base = '0; sad_vec = '0; out_ready = 1'b1;
        fill(16'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sad",   32'(best_sad),  32'd0);
        check("rst_idx",   32'(best_idx),  32'd0);
        check("rst_cnt",   32'(beat_cnt),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);

        // One-beat search, descending SADs, latency LVL+1 = 5
        for (int k = 0; k < NC; k++) cand[k] = 16'(9 - k);
        sb.push_back('{sad: 16'd1, idx: 8'd8, cnt: 16'd1});
        beat(1'b1, 1'b1, 8'd0);
        idle();
        early = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) early = 1'b1;
        end
        check("t1_not_early", 32'(early), 32'd0);
        @(negedge clk);
        check("t1_latency", 32'(out_valid), 32'd1);
        repeat (3) idle();
        check("t1_drop", 32'(out_valid), 32'd0);

        // All equal: tie rule inside the tree
        fill(16'd7);
        sb.push_back('{sad: 16'd7, idx: 8'd4, cnt: 16'd1});
        beat(1'b1, 1'b1, 8'd4);
        idle();
        wait_valid("t2");
        check("t2_hi_valid", 32'(out_valid1), 32'd1);
        check("t2_hi_sad",   32'(best_sad1),  32'd7);
        check("t2_hi_idx",   32'(best_idx1),  32'd12);
        repeat (3) idle();

        // Three-beat search, back-to-back beats, cross-beat tie in beat 3
        fill(16'd50);
        sb.push_back('{sad: 16'd3, idx: 8'd14, cnt: 16'd3});
        beat(1'b1, 1'b0, 8'd0);
        fill(16'd100); cand[5] = 16'd3;
        beat(1'b0, 1'b0, 8'd9);
        fill(16'd200); cand[0] = 16'd3;
        beat(1'b0, 1'b1, 8'd18);
        idle();
        wait_valid("t3");
        check("t3_hi_idx", 32'(best_idx1), 32'd18);
        check("t3_hi_cnt", 32'(beat_cnt1), 32'd3);
        repeat (3) idle();

        // Stalled consumer: hold, overwrite, overflow, single transfer
        out_ready = 1'b0;
        fill(16'd20); cand[2] = 16'd5;
        beat(1'b1, 1'b1, 8'd0);
        idle();
        wait_valid("t4a");
        check("t4a_sad", 32'(best_sad), 32'd5);
        check("t4a_idx", 32'(best_idx), 32'd2);
        check("t4a_ovf", 32'(overflow), 32'd0);
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!out_valid || best_sad !== 16'd5 || best_idx !== 8'd2 || beat_cnt !== 16'd1)
                stable = 1'b0;
        end
        check("t4a_hold", 32'(stable), 32'd1);
        fill(16'd30); cand[7] = 16'd6;
        sb.push_back('{sad: 16'd6, idx: 8'd107, cnt: 16'd1});
        beat(1'b1, 1'b1, 8'd100);
        idle();
        repeat (6) @(negedge clk);
        check("t4b_valid", 32'(out_valid), 32'd1);
        check("t4b_sad",   32'(best_sad),  32'd6);
        check("t4b_ovf",   32'(overflow),  32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_one_xfer", 32'(out_valid), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Reset mid-search after 2 of 3 beats
        fill(16'd40);
        beat(1'b1, 1'b0, 8'd0);
        beat(1'b0, 1'b0, 8'd9);
        @(posedge clk); #1;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_sad",   32'(best_sad),  32'd0);
        check("t5_cnt",   32'(beat_cnt),  32'd0);
        check("t5_ovf",   32'(overflow),  32'd0);
        check("t5_hi_ovf", 32'(overflow1), 32'd0);
        fill(16'd1);
        beat(1'b0, 1'b1, 8'd0);
        beat(1'b0, 1'b0, 8'd0);
        idle();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t5_orphan_dropped", 32'(seen), 32'd0);
        fill(16'd60); cand[3] = 16'd11;
        sb.push_back('{sad: 16'd11, idx: 8'h23, cnt: 16'd2});
        beat(1'b1, 1'b0, 8'h20);
        fill(16'd60);
        beat(1'b0, 1'b1, 8'h29);
        idle();
        wait_valid("t5_fresh");
        repeat (3) idle();

        // Index wrap, then all-max SADs, as back-to-back one-beat searches
        fill(16'd500); cand[6] = 16'd10;
        sb.push_back('{sad: 16'd10, idx: 8'h02, cnt: 16'd1});
        sb.push_back('{sad: 16'hFFFF, idx: 8'h10, cnt: 16'd1});
        beat(1'b1, 1'b1, 8'hFC);
        fill(16'hFFFF);
        beat(1'b1, 1'b1, 8'h10);
        idle();
        wait_valid("t6");
        @(negedge clk);
        check("t6_b2b_valid", 32'(out_valid), 32'd1);
        check("t6_hi_sad", 32'(best_sad1), 32'hFFFF);
        check("t6_hi_idx", 32'(best_idx1), 32'h18);
        repeat (3) idle();
        check("t6_drop", 32'(out_valid), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
